// File: rtl/mem_io_bridge_if.sv
// Processor-side memory bus: address, write data and strobe out; read data back.
// Read data arrives one cycle after the address.
interface mem_io_bridge_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_bridge.sv
// Address decoder between the processor bus and a synchronous RAM, with an LED register,
// a tick timer and a synchronized switch port; every region reads back with 1-cycle latency.
module mem_io_bridge #(
    parameter int unsigned RAM_AW = 7,
    parameter int unsigned LED_W  = 10,
    parameter int unsigned SW_W   = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    mem_io_bridge_if.slave    bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_wren,
    input  logic [15:0]       ram_q,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LEDR,
    output logic              tmr_irq
);

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RAM  = 3'd1,
        SEL_LED  = 3'd2,
        SEL_TMR  = 3'd3,
        SEL_SW   = 3'd4
    } sel_e;

    sel_e              w_sel;
    sel_e              r_rd_sel;
    logic [LED_W-1:0]  r_led;
    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic [15:0]       r_count;
    logic [15:0]       r_period;
    logic              r_en;
    logic              r_flag;
    logic [15:0]       r_tmr_q;
    logic [15:0]       w_tmr_rd;
    logic [15:0]       w_led16;
    logic [15:0]       w_sw16;
    logic              w_tmr_wr;
    logic              w_cnt_wr;
    logic              w_per_wr;
    logic              w_ctrl_wr;
    logic              w_stat_clr;
    logic              w_led_wr;
    logic              w_expire;
    logic              w_unused_addr;

    always_comb begin
        case (bus.ADDR[15:12])
            4'h0:    w_sel = SEL_RAM;
            4'h1:    w_sel = SEL_LED;
            4'h2:    w_sel = SEL_TMR;
            4'h3:    w_sel = SEL_SW;
            default: w_sel = SEL_NONE;
        endcase
    end

    assign w_unused_addr = ^bus.ADDR;

    assign w_led_wr   = bus.W && (w_sel == SEL_LED);
    assign w_tmr_wr   = bus.W && (w_sel == SEL_TMR);
    assign w_cnt_wr   = w_tmr_wr && (bus.ADDR[1:0] == 2'd0);
    assign w_per_wr   = w_tmr_wr && (bus.ADDR[1:0] == 2'd1);
    assign w_ctrl_wr  = w_tmr_wr && (bus.ADDR[1:0] == 2'd2);
    assign w_stat_clr = w_tmr_wr && (bus.ADDR[1:0] == 2'd3) && bus.DOUT[0];

    // A processor write to COUNT takes the cycle, so no reload and no flag.
    assign w_expire = r_en && !w_cnt_wr && (r_period != '0) && (r_count == r_period - 16'd1);

    assign ram_addr = bus.ADDR[RAM_AW-1:0];
    assign ram_data = bus.DOUT;
    assign ram_wren = Resetn && bus.W && (w_sel == SEL_RAM);

    always_comb begin
        w_tmr_rd = '0;
        case (bus.ADDR[1:0])
            2'd0:    w_tmr_rd = r_count;
            2'd1:    w_tmr_rd = r_period;
            2'd2:    w_tmr_rd[0] = r_en;
            default: w_tmr_rd[0] = r_flag;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_rd_sel  <= SEL_NONE;
            r_tmr_q   <= '0;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_count   <= '0;
            r_period  <= '0;
            r_en      <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            r_rd_sel  <= w_sel;
            r_tmr_q   <= w_tmr_rd;
            if (w_led_wr) r_led <= bus.DOUT[LED_W-1:0];
            if (w_cnt_wr) begin
                r_count <= bus.DOUT;
            end else if (w_expire) begin
                r_count <= '0;
            end else if (r_en) begin
                r_count <= r_count + 16'd1;
            end
            if (w_per_wr)  r_period <= bus.DOUT;
            if (w_ctrl_wr) r_en     <= bus.DOUT[0];
            // An expiry in the same cycle as a clear leaves the flag set.
            if (w_expire) begin
                r_flag <= 1'b1;
            end else if (w_stat_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_led16 = '0;
        w_led16[LED_W-1:0] = r_led;
        w_sw16 = '0;
        w_sw16[SW_W-1:0] = r_sw_sync;
    end

    always_comb begin
        bus.DIN = '0;
        case (r_rd_sel)
            SEL_RAM: bus.DIN = ram_q;
            SEL_LED: bus.DIN = w_led16;
            SEL_TMR: bus.DIN = r_tmr_q;
            SEL_SW:  bus.DIN = w_sw16;
            default: bus.DIN = '0;
        endcase
    end

    assign LEDR    = r_led;
    assign tmr_irq = r_flag;

endmodule
